whack_round_ctrl: RTL and testbench
===================================

# whack_round_ctrl

Round scheduler for the whack-a-mole game. Requests a mole from the mole picker and holds it up for a difficulty-dependent window. It judges button presses against that mole, keeps score and miss count, and ends the game after a configured number of misses. It sits between the mole picker (`enable`/`mole`), the debounced button pulses, and the display/score logic.

## Interface
Parameters:
- `TICK_DIV`, 100000: clock cycles per game tick (1 ms at 100 MHz).
- `GAP_TICKS`, 200: ticks with no mole shown between rounds.
- `WAIT_TICKS`, 16: ticks to wait for a non-zero `mole` before re-requesting.
- `MAX_MISSES`, 3: miss count that ends the game (1..15).

Ports:
- `CLK100MHZ` in 1: single system clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: level or pulse; begins a game from IDLE or OVER.
- `difficulty` in 2: selects show window; sampled on entry to SHOW.
- `buttons` in 8: one-cycle press pulses, bit i = hole i (already debounced).
- `mole` in 8: one-hot mole from the picker; 0 = none yet.
- `enable` out 1: one-cycle request pulse to the mole picker.
- `active_mole` out 8: one-hot lit hole; 0 outside SHOW.
- `score` out 8: hits, saturating at 255.
- `misses` out 4: timeouts plus wrong presses.
- `game_over` out 1: high in OVER.
- `state` out 3: encoded state for debug/display.

## Operation
- States and encodings: IDLE=0, REQ=1, WAIT_MOLE=2, SHOW=3, GAP=4, OVER=5.
- **IDLE.** Outputs are quiescent. On `start`, clear `score` and `misses`, then go to REQ.
- **REQ.** `enable`=1 for exactly this one cycle, then go to WAIT_MOLE.
- **WAIT_MOLE.**
  - When `mole`≠0, latch it into `active_mole` and go to SHOW.
  - If more than one bit is set, latch only the lowest set bit.
  - After WAIT_TICKS ticks with `mole`=0, return to REQ. This is a retry and is not counted as a miss.
- **SHOW.** The window length W is set by `difficulty`: 00→1000, 01→700, 10→500, 11→300 ticks. Each cycle, one of the following applies, in this priority order:
  - **Hit:** `buttons & active_mole` ≠ 0. `score`+1 (saturating), go to GAP.
  - **Wrong press:** `buttons` ≠ 0 with no hit. `misses`+1 and stay in SHOW. The window is not restarted. Several wrong bits in one cycle count as 1 miss.
  - **Expiry:** the W ticks have elapsed. `misses`+1, go to GAP.
- **Hit vs. expiry.** A hit and expiry in the same cycle count as a hit only.
- **Miss limit.** Any increment that makes `misses`==MAX_MISSES goes to OVER instead of SHOW/GAP. `misses` never exceeds MAX_MISSES.
- **GAP.** `active_mole`=0 for GAP_TICKS ticks, then go to REQ.
- **OVER.** `game_over`=1, and `score`/`misses` hold. On `start`, clear both and go to REQ.
- **`start` during play.** Ignored in REQ, WAIT_MOLE, SHOW and GAP.
- **`buttons` outside SHOW.** Ignored.
- **Reset mid-operation.** Returns to IDLE on the next edge regardless of state. Any pending request or window is discarded.

## Timing
- **Reset values.** `state`=IDLE, `enable`=0, `active_mole`=0, `score`=0, `misses`=0, `game_over`=0. Internal tick and window counters are 0.
- **Registered outputs.** All outputs are registered and change on the edge after the causing input.
- **`start` latency.** `start` sampled high in IDLE/OVER gives `state`=REQ and `enable`=1 on the next cycle.
- **Tick counter.** Restarts on every state entry. A duration of N ticks is exactly N·TICK_DIV cycles, counted from the first cycle in the state.
- **SHOW duration.**
  - `active_mole` is valid from the first SHOW cycle.
  - With no press, SHOW lasts exactly W·TICK_DIV cycles, then GAP is entered.
  - A hit in SHOW cycle k gives GAP on cycle k+1, with `active_mole`=0 and `score` updated on the same edge.
- **WAIT_MOLE latency.** `mole` seen non-zero in cycle k gives SHOW on k+1.
- **Re-request period.** WAIT_MOLE retries issue `enable` no more often than once per WAIT_TICKS·TICK_DIV+1 cycles.
- **Counter widths.**
  - Cycle counter: ⌈log2 TICK_DIV⌉ bits.
  - Tick counter: 10 bits (max 1000).
  - Neither may wrap inside a state.

## Test plan
Run all scenarios with TICK_DIV=4, GAP_TICKS=2, WAIT_TICKS=3, MAX_MISSES=3.
- **Reset then start.** Assert `reset` 2 cycles, then pulse `start` → next cycle `state`=1 and `enable`=1 for exactly 1 cycle, then `state`=2.
- **Hit.** Picker returns `mole`=8'h10 in WAIT_MOLE; press `buttons`=8'h10 in 3rd SHOW cycle → `score`=1, `active_mole`=0 next cycle, GAP lasts 8 cycles, then `enable` pulses.
- **Timeout.** `difficulty`=11, no presses → SHOW lasts 1200 cycles, `misses`=1, then GAP.
- **Wrong press, then hit.** `active_mole`=8'h01, `buttons`=8'h06 → `misses`+1, still SHOW. Then `buttons`=8'h01 → `score`+1.
- **Simultaneous hit and expiry.** `buttons`=8'h01 on the final SHOW cycle → score increments, misses unchanged.
- **Game over, restart and reset.**
  - Three misses → `game_over`=1, `state`=5, counters hold.
  - Pulsing `start` clears `score`/`misses` and enters REQ.
  - `reset` asserted mid-SHOW → all outputs at reset values next cycle.
  - Holding `mole`=0 in WAIT_MOLE → `enable` re-pulses every 13 cycles with `misses` unchanged.

Source files
------------

// File: rtl/whack_round_ctrl.sv
// whack_round_ctrl: round scheduler for the whack-a-mole game.
// Requests a mole from the picker, shows it for a difficulty-dependent
// window, judges button presses, and keeps score and miss count until the
// configured miss limit ends the game.
//
// Ports:
//   CLK100MHZ   in   system clock, all logic on rising edge
//   reset       in   synchronous active-high reset
//   start       in   begin a game from IDLE or OVER
//   difficulty  in 2 show-window select, sampled on entry to SHOW
//   buttons     in 8 one-cycle debounced press pulses, bit i = hole i
//   mole        in 8 one-hot mole from picker, 0 = none yet
//   enable      out  one-cycle request pulse to the picker
//   active_mole out 8 lit hole (one-hot), 0 outside SHOW
//   score       out 8 hit count, saturating at 255
//   misses      out 4 timeouts plus wrong presses
//   game_over   out  high in OVER
//   state       out 3 encoded FSM state
module whack_round_ctrl #(
  parameter int unsigned TICK_DIV   = 100000,
  parameter int unsigned GAP_TICKS  = 200,
  parameter int unsigned WAIT_TICKS = 16,
  parameter int unsigned MAX_MISSES = 3
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] difficulty,
  input  logic [7:0] buttons,
  input  logic [7:0] mole,
  output logic       enable,
  output logic [7:0] active_mole,
  output logic [7:0] score,
  output logic [3:0] misses,
  output logic       game_over,
  output logic [2:0] state
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_REQ       = 3'd1;
  localparam logic [2:0] S_WAIT_MOLE = 3'd2;
  localparam logic [2:0] S_SHOW      = 3'd3;
  localparam logic [2:0] S_GAP       = 3'd4;
  localparam logic [2:0] S_OVER      = 3'd5;

  logic [2:0]    state_q,  state_d;
  logic [CW-1:0] cyc_q,    cyc_d;
  logic [9:0]    tick_q,   tick_d;
  logic [9:0]    win_q,    win_d;
  logic [7:0]    active_q, active_d;
  logic [7:0]    score_q,  score_d;
  logic [3:0]    misses_q, misses_d;
  logic          enable_q;
  logic          over_q;

  logic last_cyc;
  logic wait_done;
  logic gap_done;
  logic show_done;
  logic hit;
  logic press;
  logic at_limit;
  logic timed;

  function automatic logic [9:0] window_ticks(input logic [1:0] d);
    case (d)
      2'b00:   window_ticks = 10'd1000;
      2'b01:   window_ticks = 10'd700;
      2'b10:   window_ticks = 10'd500;
      default: window_ticks = 10'd300;
    endcase
  endfunction

  assign last_cyc  = (cyc_q == CW'(TICK_DIV - 1));
  assign wait_done = last_cyc && (tick_q == 10'(WAIT_TICKS - 1));
  assign gap_done  = last_cyc && (tick_q == 10'(GAP_TICKS - 1));
  assign show_done = last_cyc && (tick_q == (win_q - 10'd1));
  assign hit       = |(buttons & active_q);
  assign press     = |buttons;
  assign at_limit  = ((misses_q + 4'd1) == 4'(MAX_MISSES));
  assign timed     = (state_q == S_WAIT_MOLE) || (state_q == S_SHOW) ||
                     (state_q == S_GAP);

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    score_d  = score_q;
    misses_d = misses_q;
    win_d    = win_q;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          score_d  = '0;
          misses_d = '0;
          state_d  = S_REQ;
        end
      end
      S_REQ: state_d = S_WAIT_MOLE;
      S_WAIT_MOLE: begin
        if (mole != '0) begin
          // Isolate lowest set bit so a multi-hot mole still lights one hole.
          active_d = mole & (~mole + 8'd1);
          win_d    = window_ticks(difficulty);
          state_d  = S_SHOW;
        end else if (wait_done) begin
          state_d = S_REQ;
        end
      end
      S_SHOW: begin
        if (hit) begin
          score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
          state_d = S_GAP;
        end else if (press) begin
          misses_d = misses_q + 4'd1;
          if (at_limit) state_d = S_OVER;
        end else if (show_done) begin
          misses_d = misses_q + 4'd1;
          state_d  = at_limit ? S_OVER : S_GAP;
        end
      end
      S_GAP: begin
        if (gap_done) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != S_SHOW) active_d = '0;
  end

  // Counters run only in timed states and restart on every state entry.
  // A wrong press on the final SHOW cycle keeps the counters parked there so
  // expiry is judged again next cycle instead of the window running past W.
  always_comb begin
    cyc_d  = cyc_q;
    tick_d = tick_q;
    if ((state_d != state_q) || !timed) begin
      cyc_d  = '0;
      tick_d = '0;
    end else if (last_cyc) begin
      if (!((state_q == S_SHOW) && show_done)) begin
        cyc_d  = '0;
        tick_d = tick_q + 10'd1;
      end
    end else begin
      cyc_d = cyc_q + CW'(1);
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cyc_q    <= '0;
      tick_q   <= '0;
      win_q    <= '0;
      active_q <= '0;
      score_q  <= '0;
      misses_q <= '0;
      enable_q <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      tick_q   <= tick_d;
      win_q    <= win_d;
      active_q <= active_d;
      score_q  <= score_d;
      misses_q <= misses_d;
      enable_q <= (state_d == S_REQ);
      over_q   <= (state_d == S_OVER);
    end
  end

  assign enable      = enable_q;
  assign active_mole = active_q;
  assign score       = score_q;
  assign misses      = misses_q;
  assign game_over   = over_q;
  assign state       = state_q;

endmodule

// File: tb/tb_whack_round_ctrl.sv
// Bench for whack_round_ctrl: directed vector table, multi-cycle corner
// sequences, and randomized stimulus compared against a cycle-count model.
module tb_whack_round_ctrl;

  localparam int TD  = 4;
  localparam int GT  = 2;
  localparam int WT  = 3;
  localparam int MM  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [1:0] difficulty = '0;
  logic [7:0] buttons = '0;
  logic [7:0] mole = '0;
  logic       enable;
  logic [7:0] active_mole;
  logic [7:0] score;
  logic [3:0] misses;
  logic       game_over;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  whack_round_ctrl #(
    .TICK_DIV(TD),
    .GAP_TICKS(GT),
    .WAIT_TICKS(WT),
    .MAX_MISSES(MM)
  ) dut (
    .CLK100MHZ(clk),
    .reset(rst),
    .start(start),
    .difficulty(difficulty),
    .buttons(buttons),
    .mole(mole),
    .enable(enable),
    .active_mole(active_mole),
    .score(score),
    .misses(misses),
    .game_over(game_over),
    .state(state)
  );

  // Reference model: durations tracked as raw cycles spent in the state.
  int m_state = 0;
  int m_en = 0;
  int m_act = 0;
  int m_score = 0;
  int m_miss = 0;
  int m_go = 0;
  int m_cyc = 0;
  int m_win = 0;

  function automatic int low_bit(input int v);
    for (int i = 0; i < 8; i++)
      if (v[i]) return (1 << i);
    return 0;
  endfunction

  function automatic int win_cycles(input int d);
    int t;
    t = (d == 0) ? 1000 : (d == 1) ? 700 : (d == 2) ? 500 : 300;
    return t * TD;
  endfunction

  task automatic model_update(input int r, input int s, input int d,
                              input int b, input int m);
    int nxt;
    nxt = m_state;
    if (r != 0) begin
      m_state = 0; m_en = 0; m_act = 0; m_score = 0; m_miss = 0;
      m_go = 0; m_cyc = 0;
      return;
    end
    case (m_state)
      0, 5: if (s != 0) begin m_score = 0; m_miss = 0; nxt = 1; end
      1: nxt = 2;
      2: begin
        if (m != 0) begin
          m_act = low_bit(m);
          m_win = win_cycles(d);
          nxt = 3;
        end else if (m_cyc + 1 >= WT * TD) begin
          nxt = 1;
        end
      end
      3: begin
        if ((b & m_act) != 0) begin
          if (m_score < 255) m_score++;
          nxt = 4;
        end else if (b != 0) begin
          m_miss++;
          if (m_miss == MM) nxt = 5;
        end else if (m_cyc + 1 >= m_win) begin
          m_miss++;
          nxt = (m_miss == MM) ? 5 : 4;
        end
      end
      4: if (m_cyc + 1 >= GT * TD) nxt = 1;
      default: nxt = 0;
    endcase
    if (nxt != m_state) m_cyc = 0;
    else m_cyc++;
    m_state = nxt;
    m_en = (nxt == 1) ? 1 : 0;
    m_go = (nxt == 5) ? 1 : 0;
    if (nxt != 3) m_act = 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pack_out(input int st, input int en, input int ac,
                                  input int sc, input int mi, input int go);
    return (st << 22) | (en << 21) | (ac << 13) | (sc << 5) | (mi << 1) | go;
  endfunction

  function automatic int dut_out();
    return pack_out(int'(state), int'(enable), int'(active_mole),
                    int'(score), int'(misses), int'(game_over));
  endfunction

  task automatic step(input logic r, input logic s, input logic [1:0] d,
                      input logic [7:0] b, input logic [7:0] m);
    rst = r; start = s; difficulty = d; buttons = b; mole = m;
    @(posedge clk);
    #1;
    model_update(int'(r), int'(s), int'(d), int'(b), int'(m));
    chk("model", dut_out(),
        pack_out(m_state, m_en, m_act, m_score, m_miss, m_go));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
  endtask

  task automatic wait_state(input logic [2:0] s, input int lim);
    int k;
    k = 0;
    while (state != s && k < lim) begin
      idle();
      k++;
    end
    chk("wait_state", int'(state), int'(s));
  endtask

  typedef struct {
    logic       r;
    logic       s;
    logic [1:0] d;
    logic [7:0] b;
    logic [7:0] m;
    int         exp;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic r, input logic s, input logic [1:0] d,
                              input logic [7:0] b, input logic [7:0] m,
                              input int st, input int en, input int ac,
                              input int sc, input int mi, input int go);
    vec_t v;
    v.r = r; v.s = s; v.d = d; v.b = b; v.m = m;
    v.exp = pack_out(st, en, ac, sc, mi, go);
    return v;
  endfunction

  initial begin
    int n;
    int rate;
    logic [7:0] rb;
    logic [7:0] rm;

    vecs[0]  = mk(1, 0, 0, 8'h00, 8'h00, 0, 0, 'h00, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 8'h00, 8'h00, 0, 0, 'h00, 0, 0, 0);
    vecs[2]  = mk(0, 1, 0, 8'h00, 8'h00, 1, 1, 'h00, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 8'h00, 8'h00, 2, 0, 'h00, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 8'h00, 8'h30, 3, 0, 'h10, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 8'h01, 8'h00, 3, 0, 'h10, 0, 1, 0);
    vecs[6]  = mk(0, 0, 0, 8'h10, 8'h00, 4, 0, 'h00, 1, 1, 0);
    vecs[7]  = mk(0, 1, 0, 8'hFF, 8'hFF, 4, 0, 'h00, 1, 1, 0);
    for (int i = 8; i < 14; i++)
      vecs[i] = mk(0, 0, 0, 8'h00, 8'h00, 4, 0, 'h00, 1, 1, 0);
    vecs[14] = mk(0, 0, 0, 8'h00, 8'h00, 1, 1, 'h00, 1, 1, 0);
    vecs[15] = mk(0, 0, 0, 8'h00, 8'h00, 2, 0, 'h00, 1, 1, 0);
    vecs[16] = mk(0, 0, 1, 8'h00, 8'h06, 3, 0, 'h02, 1, 1, 0);
    vecs[17] = mk(1, 0, 0, 8'h02, 8'h00, 0, 0, 'h00, 0, 0, 0);
    vecs[18] = mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 'h00, 0, 0, 0);
    vecs[19] = mk(0, 1, 0, 8'h00, 8'h00, 1, 1, 'h00, 0, 0, 0);

    #2;
    for (int i = 0; i < 20; i++) begin
      step(vecs[i].r, vecs[i].s, vecs[i].d, vecs[i].b, vecs[i].m);
      chk($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
    end

    // Timeout at difficulty 11: 300 ticks * 4 cycles.
    step(1, 0, 0, 8'h00, 8'h00);
    step(0, 1, 0, 8'h00, 8'h00);
    idle();
    step(0, 0, 2'b11, 8'h00, 8'h01);
    chk("show_entry", int'(state), 3);
    n = 0;
    while (state == 3'd3 && n < 1300) begin
      idle();
      n++;
    end
    chk("timeout_len", n, 1200);
    chk("timeout_miss", int'(misses), 1);
    chk("timeout_gap", int'(state), 4);

    // Hit on the final SHOW cycle counts as hit only.
    wait_state(3'd2, 20);
    step(0, 0, 2'b11, 8'h00, 8'h01);
    repeat (1199) idle();
    chk("final_still_show", int'(state), 3);
    step(0, 0, 0, 8'h01, 8'h00);
    chk("final_hit_score", int'(score), 1);
    chk("final_hit_miss", int'(misses), 1);
    chk("final_hit_gap", int'(state), 4);

    // Wrong press then hit.
    wait_state(3'd2, 20);
    step(0, 0, 0, 8'h00, 8'h01);
    step(0, 0, 0, 8'h06, 8'h00);
    chk("wrong_miss", int'(misses), 2);
    chk("wrong_state", int'(state), 3);
    chk("wrong_active", int'(active_mole), 'h01);
    step(0, 0, 0, 8'h01, 8'h00);
    chk("hit_score", int'(score), 2);
    chk("hit_state", int'(state), 4);

    // Third miss ends the game; counters hold; start restarts.
    wait_state(3'd2, 20);
    step(0, 0, 0, 8'h00, 8'h01);
    step(0, 0, 0, 8'h02, 8'h00);
    chk("over_state", int'(state), 5);
    chk("over_flag", int'(game_over), 1);
    chk("over_miss", int'(misses), 3);
    repeat (5) step(0, 0, 0, 8'hFF, 8'hFF);
    chk("over_hold", dut_out(), pack_out(5, 0, 0, 2, 3, 1));
    step(0, 1, 0, 8'h00, 8'h00);
    chk("restart", dut_out(), pack_out(1, 1, 0, 0, 0, 0));

    // Re-request period with mole held at zero.
    for (int r = 0; r < 2; r++) begin
      n = 0;
      do begin
        idle();
        n++;
      end while (enable != 1'b1 && n < 20);
      chk("rereq_period", n, WT * TD + 1);
      chk("rereq_miss", int'(misses), 0);
    end

    // Randomized play against the model.
    rate = 30;
    for (int i = 0; i < 20000; i++) begin
      if (i % 2000 == 0) rate = ($urandom_range(0, 1) == 0) ? 30 : 3000;
      rb = 8'h00;
      if ($urandom_range(0, rate - 1) == 0) begin
        if ($urandom_range(0, 1) == 0) rb = 8'h01 << $urandom_range(0, 7);
        else rb = 8'($urandom);
      end
      rm = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      step($urandom_range(0, 499) == 0, $urandom_range(0, 7) == 0,
           2'($urandom_range(0, 3)), rb, rm);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
